systolic_row_pipe: RTL



---
 rtl/vta_gemm_pkg.sv | 24 ++
 rtl/systolic_pipe_stage.sv | 91 +++++++++
 rtl/systolic_row_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/vta_gemm_pkg.sv
// Shared GEMM-core definitions.
// Holds the default element/accumulator widths and block size used by the
// systolic row pipeline, plus the MAC helper that forms one sign-extended
// lane product at accumulator width.
package vta_gemm_pkg;

  localparam int DEF_INP_WIDTH  = 8;
  localparam int DEF_WGT_WIDTH  = 8;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_BLOCK_IN   = 16;
  localparam int DEF_PROD_WIDTH = DEF_INP_WIDTH + DEF_WGT_WIDTH;

  // Signed input x signed weight, full-precision product sign-extended to
  // accumulator width so it can be added with plain wrap-around arithmetic.
  function automatic logic [DEF_ACC_WIDTH-1:0] mac_ext(
    input logic signed [DEF_INP_WIDTH-1:0] inp,
    input logic signed [DEF_WGT_WIDTH-1:0] wgt
  );
    logic signed [DEF_PROD_WIDTH-1:0] prod;
    prod = DEF_PROD_WIDTH'(inp) * DEF_PROD_WIDTH'(wgt);
    return {{(DEF_ACC_WIDTH-DEF_PROD_WIDTH){prod[DEF_PROD_WIDTH-1]}}, prod};
  endfunction

endpackage

// File: rtl/systolic_pipe_stage.sv
// One register cut of the systolic row pipeline.
// Adds M lane products to the incoming partial sum and registers the result
// together with the lanes later stages still need. Elastic: the stage loads
// whenever it is empty or its downstream accepts.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   up_valid/up_ready   upstream handshake (up_ready = !valid || dn_ready)
//   up_inp/up_wgt       LANES_IN lanes; the lowest M are consumed here
//   up_sum              partial sum from the previous stage
//   dn_valid/dn_ready   downstream handshake
//   dn_inp/dn_wgt       registered unconsumed lanes (tied to zero when none)
//   dn_sum              registered partial sum
module systolic_pipe_stage
  import vta_gemm_pkg::*;
#(
  parameter int M         = 4,
  parameter int LANES_IN  = 16,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  localparam int LANES_OUT = LANES_IN - M,
  localparam int OUT_LANES = (LANES_OUT > 0) ? LANES_OUT : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               up_valid,
  output logic                               up_ready,
  input  logic [LANES_IN*DEF_INP_WIDTH-1:0]  up_inp,
  input  logic [LANES_IN*DEF_WGT_WIDTH-1:0]  up_wgt,
  input  logic [ACC_WIDTH-1:0]               up_sum,
  output logic                               dn_valid,
  input  logic                               dn_ready,
  output logic [OUT_LANES*DEF_INP_WIDTH-1:0] dn_inp,
  output logic [OUT_LANES*DEF_WGT_WIDTH-1:0] dn_wgt,
  output logic [ACC_WIDTH-1:0]               dn_sum
);

  logic                 valid_r;
  logic [ACC_WIDTH-1:0] sum_r;
  logic [ACC_WIDTH-1:0] acc_s;
  logic                 ready_s;

  // A bubble or a drained slot can always be refilled.
  assign ready_s  = !valid_r || dn_ready;
  assign up_ready = ready_s;
  assign dn_valid = valid_r;
  assign dn_sum   = sum_r;

  // Chained MACs over this stage's lanes, wrapping at accumulator width.
  always_comb begin
    acc_s = up_sum;
    for (int i = 0; i < M; i++) begin
      acc_s = acc_s + mac_ext(up_inp[i*DEF_INP_WIDTH +: DEF_INP_WIDTH],
                              up_wgt[i*DEF_WGT_WIDTH +: DEF_WGT_WIDTH]);
    end
  end

  // Valid/partial-sum register; data only changes when a real beat lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      sum_r   <= {ACC_WIDTH{1'b0}};
    end else if (ready_s) begin
      valid_r <= up_valid;
      if (up_valid) begin
        sum_r <= acc_s;
      end
    end
  end

  if (LANES_OUT > 0) begin : g_carry
    logic [LANES_OUT*DEF_INP_WIDTH-1:0] inp_r;
    logic [LANES_OUT*DEF_WGT_WIDTH-1:0] wgt_r;

    // Carry the not-yet-consumed lanes alongside the partial sum.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        inp_r <= {(LANES_OUT*DEF_INP_WIDTH){1'b0}};
        wgt_r <= {(LANES_OUT*DEF_WGT_WIDTH){1'b0}};
      end else if (ready_s && up_valid) begin
        inp_r <= up_inp[M*DEF_INP_WIDTH +: LANES_OUT*DEF_INP_WIDTH];
        wgt_r <= up_wgt[M*DEF_WGT_WIDTH +: LANES_OUT*DEF_WGT_WIDTH];
      end
    end

    assign dn_inp = inp_r;
    assign dn_wgt = wgt_r;
  end else begin : g_tail
    assign dn_inp = {(OUT_LANES*DEF_INP_WIDTH){1'b0}};
    assign dn_wgt = {(OUT_LANES*DEF_WGT_WIDTH){1'b0}};
  end

endmodule

// File: rtl/systolic_row_pipe.sv
// Pipelined, elastic systolic row: one signed dot product of BLOCK_IN
// input/weight lanes plus an incoming accumulator, cut into
// NUM_STAGES = BLOCK_IN/MACS_PER_STAGE register stages.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_valid/s_ready     input beat handshake (s_ready ripples from m_ready)
//   s_inp/s_wgt         packed lanes, lane i at [i*W +: W]
//   s_acc, s_acc_clr    incoming partial sum, and "start from zero" flag
//   m_valid/m_ready     result handshake
//   m_sum               result, driven straight from the last stage register
module systolic_row_pipe
  import vta_gemm_pkg::*;
#(
  parameter int INP_WIDTH      = DEF_INP_WIDTH,
  parameter int WGT_WIDTH      = DEF_WGT_WIDTH,
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int BLOCK_IN       = DEF_BLOCK_IN,
  parameter int MACS_PER_STAGE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [INP_WIDTH*BLOCK_IN-1:0] s_inp,
  input  logic [WGT_WIDTH*BLOCK_IN-1:0] s_wgt,
  input  logic [ACC_WIDTH-1:0]          s_acc,
  input  logic                          s_acc_clr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [ACC_WIDTH-1:0]          m_sum
);

  localparam int M          = MACS_PER_STAGE;
  localparam int NUM_STAGES = BLOCK_IN / MACS_PER_STAGE;

  // First lane slot of stage j's input inside the flattened lane chain;
  // stage j sees BLOCK_IN - j*M lanes, so the chain is triangular.
  function automatic int lane_off(input int j);
    return j * BLOCK_IN - (M * j * (j - 1)) / 2;
  endfunction

  localparam int CHAIN_LANES = lane_off(NUM_STAGES);

  if (BLOCK_IN % MACS_PER_STAGE != 0) begin : g_bad_split
    $error("systolic_row_pipe: MACS_PER_STAGE must divide BLOCK_IN");
  end
  if (INP_WIDTH != DEF_INP_WIDTH || WGT_WIDTH != DEF_WGT_WIDTH ||
      ACC_WIDTH != DEF_ACC_WIDTH) begin : g_bad_width
    $error("systolic_row_pipe: widths must match vta_gemm_pkg defaults");
  end

  logic [CHAIN_LANES*INP_WIDTH-1:0]     inp_chain_s;
  logic [CHAIN_LANES*WGT_WIDTH-1:0]     wgt_chain_s;
  logic [NUM_STAGES:0]                  valid_s;
  logic [NUM_STAGES:0][ACC_WIDTH-1:0]   sum_s;
  logic [ACC_WIDTH-1:0]                 acc_in_s;

  // Beats flagged s_acc_clr start a fresh accumulation from zero.
  always_comb begin
    if (s_acc_clr) begin
      acc_in_s = {ACC_WIDTH{1'b0}};
    end else begin
      acc_in_s = s_acc;
    end
  end

  assign inp_chain_s[0 +: BLOCK_IN*INP_WIDTH] = s_inp;
  assign wgt_chain_s[0 +: BLOCK_IN*WGT_WIDTH] = s_wgt;
  assign valid_s[0] = s_valid;
  assign sum_s[0]   = acc_in_s;
  assign m_valid    = valid_s[NUM_STAGES];
  assign m_sum      = sum_s[NUM_STAGES];
  assign s_ready    = g_stage[0].up_rdy_s;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LIN  = BLOCK_IN - k * M;
    localparam int LOUT = LIN - M;
    localparam int OUTL = (LOUT > 0) ? LOUT : 1;

    // Per-stage scalars keep the ready ripple free of self-referencing vectors.
    logic                      up_rdy_s;
    logic                      dn_rdy_s;
    logic [OUTL*INP_WIDTH-1:0] dn_inp_s;
    logic [OUTL*WGT_WIDTH-1:0] dn_wgt_s;

    systolic_pipe_stage #(
      .M        (M),
      .LANES_IN (LIN),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .up_valid(valid_s[k]),
      .up_ready(up_rdy_s),
      .up_inp  (inp_chain_s[lane_off(k)*INP_WIDTH +: LIN*INP_WIDTH]),
      .up_wgt  (wgt_chain_s[lane_off(k)*WGT_WIDTH +: LIN*WGT_WIDTH]),
      .up_sum  (sum_s[k]),
      .dn_valid(valid_s[k+1]),
      .dn_ready(dn_rdy_s),
      .dn_inp  (dn_inp_s),
      .dn_wgt  (dn_wgt_s),
      .dn_sum  (sum_s[k+1])
    );

    if (LOUT > 0) begin : g_mid
      assign dn_rdy_s = g_stage[k+1].up_rdy_s;
      assign inp_chain_s[lane_off(k+1)*INP_WIDTH +: LOUT*INP_WIDTH] = dn_inp_s;
      assign wgt_chain_s[lane_off(k+1)*WGT_WIDTH +: LOUT*WGT_WIDTH] = dn_wgt_s;
    end else begin : g_last
      // The last stage has no lanes left to forward.
      logic [OUTL*INP_WIDTH-1:0] tail_inp_unused;
      logic [OUTL*WGT_WIDTH-1:0] tail_wgt_unused;
      assign dn_rdy_s        = m_ready;
      assign tail_inp_unused = dn_inp_s;
      assign tail_wgt_unused = dn_wgt_s;
    end
  end

endmodule
